// File: rtl/inst_axi_pkg.sv
// Shared AXI4 read-channel constants and response decoding for the instruction fetch bridge.
package inst_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32    = 3'b010;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  // A single-beat read must carry RLAST; a missing one is treated like a slave error.
  function automatic logic resp_is_err(axi_resp_e resp, logic last);
    return (resp == RespSlverr) || (resp == RespDecerr) || !last;
  endfunction

endpackage

// File: rtl/inst_addr_fifo.sv
// Small synchronous FIFO holding the addresses of reads that are in flight on AXI.
module inst_addr_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Bridges the 32-bit req/gnt/rvalid instruction fetch port onto AXI4 AR/R channels,
// issuing single-beat reads and reporting bus errors with the faulting address.
module inst_axi_rd_bridge
  import inst_axi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_axi_i_narrow_req,
  input  logic [31:0] core_axi_i_narrow_addr,
  output logic        core_axi_i_narrow_gnt,
  output logic        core_axi_i_narrow_rvalid,
  output logic [31:0] core_axi_i_narrow_rdata,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [31:0] ar_addr,
  output logic [3:0]  ar_id,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  output logic [2:0]  ar_prot,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  input  logic [3:0]  r_id,
  output logic        bus_err,
  output logic [31:0] bus_err_addr
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            ar_valid_d, ar_valid_q;
  logic [31:0]     ar_addr_d, ar_addr_q;
  logic            rvalid_q, bus_err_q;
  logic [31:0]     rdata_d, rdata_q;
  logic [31:0]     err_addr_d, err_addr_q;
  logic            gnt, r_hs, err;
  logic [31:0]     fifo_head;
  logic            fifo_empty, fifo_full;
  logic            unused_sigs;

  assign ar_id    = AXI_ID;
  assign ar_len   = AXI_LEN_SINGLE;
  assign ar_size  = AXI_SIZE_32;
  assign ar_burst = AXI_BURST_INCR;
  assign ar_prot  = AXI_PROT_INSTR;

  assign ar_valid                 = ar_valid_q;
  assign ar_addr                  = ar_addr_q;
  assign r_ready                  = (cnt_q != '0);
  assign core_axi_i_narrow_gnt    = gnt;
  assign core_axi_i_narrow_rvalid = rvalid_q;
  assign core_axi_i_narrow_rdata  = rdata_q;
  assign bus_err                  = bus_err_q;
  assign bus_err_addr             = err_addr_q;

  // Responses come back in issue order, so the FIFO count always equals cnt_q.
  assign unused_sigs = ^{r_id, fifo_empty, fifo_full};

  always_comb begin
    gnt = core_axi_i_narrow_req && (!ar_valid_q || ar_ready) &&
          (cnt_q < CntW'(MAX_OUTSTANDING));
    r_hs = r_valid && r_ready;
    err  = r_hs && resp_is_err(axi_resp_e'(r_resp), r_last);

    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    if (gnt) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = core_axi_i_narrow_addr;
    end else if (ar_ready) begin
      ar_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (gnt && !r_hs) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!gnt && r_hs) begin
      cnt_d = cnt_q - 1'b1;
    end

    rdata_d    = r_hs ? r_data : rdata_q;
    err_addr_d = err ? fifo_head : err_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      rvalid_q   <= r_hs;
      rdata_q    <= rdata_d;
      bus_err_q  <= err;
      err_addr_q <= err_addr_d;
    end
  end

  inst_addr_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (32)
  ) u_addr_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (gnt),
    .wdata_i (core_axi_i_narrow_addr),
    .pop_i   (r_hs),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge with MAX_OUTSTANDING=2 and a scripted AXI slave.
module tb_inst_axi_rd_bridge;

  logic        clk, rst_n;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size, ar_prot;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  r_id;
  logic        bus_err;
  logic [31:0] bus_err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  inst_axi_rd_bridge #(
    .MAX_OUTSTANDING (2),
    .AXI_ID          (4'h0)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .core_axi_i_narrow_req    (req),
    .core_axi_i_narrow_addr   (addr),
    .core_axi_i_narrow_gnt    (gnt),
    .core_axi_i_narrow_rvalid (rvalid),
    .core_axi_i_narrow_rdata  (rdata),
    .ar_valid                 (ar_valid),
    .ar_ready                 (ar_ready),
    .ar_addr                  (ar_addr),
    .ar_id                    (ar_id),
    .ar_len                   (ar_len),
    .ar_size                  (ar_size),
    .ar_burst                 (ar_burst),
    .ar_prot                  (ar_prot),
    .r_valid                  (r_valid),
    .r_ready                  (r_ready),
    .r_data                   (r_data),
    .r_resp                   (r_resp),
    .r_last                   (r_last),
    .r_id                     (r_id),
    .bus_err                  (bus_err),
    .bus_err_addr             (bus_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rq, input logic [31:0] a, input logic ard, input logic rv,
                       input logic [31:0] rd, input logic [1:0] rr, input logic rl);
    req = rq; addr = a; ar_ready = ard; r_valid = rv; r_data = rd; r_resp = rr; r_last = rl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r_id = 4'h0; idle();
    repeat (3) @(negedge clk);
    n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_tests++; if ({ar_valid, r_ready, rvalid, bus_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {ar_valid, r_ready, rvalid, bus_err});
    end
    n_tests++; if ({ar_addr, rdata, bus_err_addr} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {ar_addr, rdata, bus_err_addr});
    end
    n_tests++; if ({ar_id, ar_len, ar_size, ar_burst, ar_prot} !== {4'h0, 8'h00, 3'b010, 2'b01, 3'b100}) begin
      n_fail++; $display("FAIL ar_consts: got %h/%h/%b/%b/%b want 0/00/010/01/100",
                         ar_id, ar_len, ar_size, ar_burst, ar_prot);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(negedge clk); drive(1'b1, 32'h1000, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1); #1;
    n_tests++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b want 1", gnt); end
    @(negedge clk);
    n_tests++; if (ar_valid !== 1'b1 || ar_addr !== 32'h1000) begin
      n_fail++; $display("FAIL single_ar: got %b/%h want 1/00001000", ar_valid, ar_addr);
    end
    idle();
    @(negedge clk);
    n_tests++; if (ar_valid !== 1'b0 || r_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_rready: got ar_valid %b r_ready %b want 0 1", ar_valid, r_ready);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 2'b00, 1'b1);
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b1 || rdata !== 32'h13 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rdata: got %b/%h/%b want 1/00000013/0", rvalid, rdata, bus_err);
    end
    n_tests++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL single_cnt0: got %b want 0", r_ready); end
    idle();
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] dat [4];
    int gi, ri_drv, ri_chk, ai;
    logic exp_g, exp_rv, exp_av, rv;
    addrs = '{32'h100, 32'h104, 32'h108, 32'h10C};
    dat   = '{32'hA000_0100, 32'hA000_0104, 32'hA000_0108, 32'hA000_010C};
    gi = 0; ri_drv = 0; ri_chk = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      exp_rv = (c == 7 || c == 8 || c == 14 || c == 15);
      exp_av = (c == 1 || c == 2 || c == 8 || c == 9);
      exp_g  = (c == 0 || c == 1 || c == 7 || c == 8);
      n_tests++; if (rvalid !== exp_rv) begin
        n_fail++; $display("FAIL b2b_rvalid c%0d: got %b want %b", c, rvalid, exp_rv);
      end
      if (exp_rv) begin
        n_tests++; if (rdata !== dat[ri_chk]) begin
          n_fail++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, rdata, dat[ri_chk]);
        end
        ri_chk++;
      end
      n_tests++; if (ar_valid !== exp_av) begin
        n_fail++; $display("FAIL b2b_arvalid c%0d: got %b want %b", c, ar_valid, exp_av);
      end
      if (exp_av) begin
        ai = (c == 1) ? 0 : (c == 2) ? 1 : (c == 8) ? 2 : 3;
        n_tests++; if (ar_addr !== addrs[ai]) begin
          n_fail++; $display("FAIL b2b_araddr c%0d: got %h want %h", c, ar_addr, addrs[ai]);
        end
      end
      rv = (c == 6 || c == 7 || c == 13 || c == 14);
      drive(gi < 4, (gi < 4) ? addrs[gi] : 32'h0, 1'b1, rv, rv ? dat[ri_drv] : 32'h0, 2'b00, 1'b1);
      if (rv) ri_drv++;
      #1;
      n_tests++; if (gnt !== exp_g) begin
        n_fail++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, gnt, exp_g);
      end
      if (exp_g) gi++;
    end
    n_tests++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", r_ready); end
    idle();
  endtask

  task automatic test_ar_stall();
    int hs;
    hs = 0;
    @(negedge clk); drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1); #1;
    n_tests++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL stall_gnt0: got %b want 1", gnt); end
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (ar_valid !== 1'b1 || ar_addr !== 32'h300) begin
        n_fail++; $display("FAIL stall_ar c%0d: got %b/%h want 1/00000300", c, ar_valid, ar_addr);
      end
      if (c < 4) drive(1'b1, 32'h304, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
      else idle();
      #1;
      n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL stall_gnt c%0d: got %b want 0", c, gnt); end
      if (ar_valid && ar_ready) hs++;
    end
    @(negedge clk);
    if (ar_valid && ar_ready) hs++;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 2'b00, 1'b1);
    @(negedge clk);
    n_tests++; if (hs !== 1) begin n_fail++; $display("FAIL stall_hs: got %0d want 1", hs); end
    n_tests++; if (rvalid !== 1'b1 || rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL stall_rdata: got %b/%h want 1/12345678", rvalid, rdata);
    end
    idle();
  endtask

  task automatic test_bus_error();
    @(negedge clk); drive(1'b1, 32'h2000, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    @(negedge clk); idle();
    @(negedge clk); drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1);
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || bus_err !== 1'b1) begin
      n_fail++; $display("FAIL err_pulse: got %b/%h/%b want 1/deadbeef/1", rvalid, rdata, bus_err);
    end
    n_tests++; if (bus_err_addr !== 32'h2000) begin
      n_fail++; $display("FAIL err_addr: got %h want 00002000", bus_err_addr);
    end
    drive(1'b1, 32'h2004, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_oneshot: got %b want 0", bus_err); end
    idle();
    @(negedge clk); drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h11, 2'b00, 1'b1);
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b1 || bus_err !== 1'b0 || bus_err_addr !== 32'h2000) begin
      n_fail++; $display("FAIL err_sticky: got %b/%b/%h want 1/0/00002000", rvalid, bus_err, bus_err_addr);
    end
    idle();
  endtask

  task automatic test_grant_and_r();
    @(negedge clk); drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    @(negedge clk); idle();
    @(negedge clk); drive(1'b1, 32'h404, 1'b1, 1'b1, 32'hAAAA_0400, 2'b00, 1'b1); #1;
    n_tests++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL gr_gnt: got %b want 1", gnt); end
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b1 || rdata !== 32'hAAAA_0400 || r_ready !== 1'b1) begin
      n_fail++; $display("FAIL gr_cnt: got %b/%h/%b want 1/aaaa0400/1", rvalid, rdata, r_ready);
    end
    n_tests++; if (ar_valid !== 1'b1 || ar_addr !== 32'h404) begin
      n_fail++; $display("FAIL gr_ar: got %b/%h want 1/00000404", ar_valid, ar_addr);
    end
    idle();
    @(negedge clk); drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB_0404, 2'b00, 1'b0);
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b1 || rdata !== 32'hBBBB_0404 || bus_err !== 1'b1) begin
      n_fail++; $display("FAIL gr_nolast: got %b/%h/%b want 1/bbbb0404/1", rvalid, rdata, bus_err);
    end
    n_tests++; if (bus_err_addr !== 32'h404 || r_ready !== 1'b0) begin
      n_fail++; $display("FAIL gr_head: got %h/%b want 00000404/0", bus_err_addr, r_ready);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    @(negedge clk); drive(1'b1, 32'h604, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    n_tests++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL rm_inflight: got %b want 1", r_ready); end
    rst_n = 1'b0; #1;
    n_tests++; if ({ar_valid, r_ready, rvalid, bus_err, gnt} !== 5'b00000) begin
      n_fail++; $display("FAIL rm_flags: got %b want 00000", {ar_valid, r_ready, rvalid, bus_err, gnt});
    end
    n_tests++; if ({ar_addr, rdata, bus_err_addr} !== 96'h0) begin
      n_fail++; $display("FAIL rm_data: got %h want 0", {ar_addr, rdata, bus_err_addr});
    end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0BAD, 2'b00, 1'b1); #1;
    n_tests++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL rm_late_rdy: got %b want 0", r_ready); end
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL rm_late_drop: got %b/%h want 0/00000000", rvalid, rdata);
    end
    drive(1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1); #1;
    n_tests++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_gnt: got %b want 1", gnt); end
    @(negedge clk);
    n_tests++; if (ar_valid !== 1'b1 || ar_addr !== 32'h700) begin
      n_fail++; $display("FAIL rm_fresh_ar: got %b/%h want 1/00000700", ar_valid, ar_addr);
    end
    idle();
    @(negedge clk); drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0700_0013, 2'b00, 1'b1);
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b1 || rdata !== 32'h0700_0013 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rm_fresh_r: got %b/%h/%b want 1/07000013/0", rvalid, rdata, bus_err);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_ar_stall();
    test_bus_error();
    test_grant_and_r();
    test_reset_mid();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
